// File: rtl/data_ram_pkg.sv
// Shared types and decode helpers for the dmem responder (and a future imem responder).
// Contents:
//   mem_mode_t   - funct3 load/store mode with named constants
//   mem_size_t   - decoded access size, SIZE_BAD for illegal modes
//   ram_state_t  - responder FSM state
//   wr_lanes_t   - write payload: byte enables plus lane-replicated data
//   mode_size()  - mode -> access size
//   mode_fault() - misaligned or illegal access detection
package data_ram_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;

    typedef logic [2:0] mem_mode_t;

    localparam mem_mode_t MEM_BYTE   = 3'b000;
    localparam mem_mode_t MEM_HALF   = 3'b001;
    localparam mem_mode_t MEM_WORD   = 3'b010;
    localparam mem_mode_t MEM_BYTE_U = 3'b100;
    localparam mem_mode_t MEM_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_BAD  = 2'd3
    } mem_size_t;

    typedef enum logic {
        RAM_IDLE = 1'b0,
        RAM_BUSY = 1'b1
    } ram_state_t;

    typedef struct packed {
        logic [LANES-1:0]  byte_en;
        logic [WORD_W-1:0] data;
    } wr_lanes_t;

    // Signedness is resolved in the core, so signed and unsigned modes share a size.
    function automatic mem_size_t mode_size(input mem_mode_t mode);
        mem_size_t size;
        case (mode)
            MEM_BYTE, MEM_BYTE_U: size = SIZE_BYTE;
            MEM_HALF, MEM_HALF_U: size = SIZE_HALF;
            MEM_WORD:             size = SIZE_WORD;
            default:              size = SIZE_BAD;
        endcase
        return size;
    endfunction

    function automatic logic mode_fault(input mem_mode_t mode, input logic [1:0] addr_lo);
        logic fault;
        case (mode_size(mode))
            SIZE_HALF: fault = addr_lo[0];
            SIZE_WORD: fault = (addr_lo != 2'b00);
            SIZE_BAD:  fault = 1'b1;
            default:   fault = 1'b0;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/data_ram_mem_align.sv
// mem_align: combinational lane steering for a 32-bit memory port.
// Ports:
//   addr_lo      in   byte offset within the word
//   write_mode   in   store funct3
//   write_data   in   store data, lane-0 aligned
//   read_mode    in   load funct3
//   read_word    in   raw word read from the array
//   write_c      out  byte enables + replicated store data (enables zero on fault)
//   read_data_c  out  selected lane, right-aligned, upper bits zero
//   write_fault_c out store is misaligned or uses an illegal mode
//   read_fault_c out  load is misaligned or uses an illegal mode
module mem_align
    import data_ram_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  mem_mode_t         write_mode,
    input  logic [WORD_W-1:0] write_data,
    input  mem_mode_t         read_mode,
    input  logic [WORD_W-1:0] read_word,
    output wr_lanes_t         write_c,
    output logic [WORD_W-1:0] read_data_c,
    output logic              write_fault_c,
    output logic              read_fault_c
);

    // Store lane enables and data replication.
    always_comb begin
        write_c.byte_en = '0;
        write_c.data    = write_data;
        write_fault_c   = mode_fault(write_mode, addr_lo);
        case (mode_size(write_mode))
            SIZE_BYTE: begin
                write_c.byte_en = 4'b0001 << addr_lo;
                write_c.data    = {4{write_data[7:0]}};
            end
            SIZE_HALF: begin
                write_c.byte_en = 4'b0011 << {addr_lo[1], 1'b0};
                write_c.data    = {2{write_data[15:0]}};
            end
            SIZE_WORD: begin
                write_c.byte_en = 4'b1111;
            end
            default: begin
                write_c.byte_en = '0;
            end
        endcase
        if (write_fault_c) begin
            write_c.byte_en = '0;
        end
    end

    // Load lane extraction; zero extension only, sign handling lives in writeback.
    always_comb begin
        read_data_c  = '0;
        read_fault_c = mode_fault(read_mode, addr_lo);
        case (mode_size(read_mode))
            SIZE_BYTE: read_data_c = {24'b0, read_word[{addr_lo, 3'b000} +: 8]};
            SIZE_HALF: read_data_c = {16'b0, (addr_lo[1] ? read_word[31:16] : read_word[15:0])};
            SIZE_WORD: read_data_c = read_word;
            default:   read_data_c = '0;
        endcase
    end

endmodule

// File: rtl/data_ram.sv
// data_ram: dmem responder between the core and the on-chip SRAM array.
// Single-cycle requests are captured when dmem_enable is high and the FSM is idle.
// Writes commit at the capture edge with per-byte enables; reads sample the array
// at the same edge (read-first) and return right-aligned, zero-extended data.
// A read optionally holds dmem_wait high for WAIT_STATES cycles afterwards.
// Optional preload hook: DATA_RAM_INIT_EN requires a non-empty INIT_FILE.
// Ports:
//   clk               in   clock
//   reset_n           in   synchronous active-low reset
//   dmem_address      in   byte address (upper bits beyond the array wrap)
//   dmem_enable       in   request strobe
//   dmem_write_data   in   store data, lane-0 aligned
//   dmem_write_enable in   store request
//   dmem_write_mode   in   store funct3
//   dmem_read_enable  in   load request
//   dmem_read_mode    in   load funct3
//   dmem_read_data    out  load result, right-aligned
//   dmem_wait         out  responder busy
//   dmem_fault        out  one-cycle pulse on misaligned/illegal request
module data_ram
    import data_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       dmem_address,
    input  logic              dmem_enable,
    input  logic [31:0]       dmem_write_data,
    input  logic              dmem_write_enable,
    input  mem_mode_t         dmem_write_mode,
    input  logic              dmem_read_enable,
    input  mem_mode_t         dmem_read_mode,
    output logic [31:0]       dmem_read_data,
    output logic              dmem_wait,
    output logic              dmem_fault
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
    localparam logic HAS_WAIT = (WAIT_STATES > 0);

    if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("data_ram: DEPTH_WORDS must be a power of two");
    end
    if (WAIT_STATES > 15) begin : g_bad_wait
        $error("data_ram: WAIT_STATES must be in 0..15");
    end

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    ram_state_t        state;
    ram_state_t        state_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              wait_next;
    logic              fault_next;
    logic [31:0]       read_data_next;

    logic [IDX_W-1:0]  index;
    logic [WORD_W-1:0] read_word;
    wr_lanes_t         write_lanes;
    logic [31:0]       read_lane;
    logic              write_fault;
    logic              read_fault;
    logic              req_fault;
    logic              capture;
    logic              do_write;
    logic              unused_addr;

    // Word index wraps modulo the array size; higher address bits are ignored.
    assign index       = dmem_address[IDX_W+1:2];
    assign unused_addr = ^dmem_address[31:IDX_W+2];
    assign read_word   = mem[index];

    assign capture   = dmem_enable && (state == RAM_IDLE);
    assign req_fault = (dmem_write_enable && write_fault) || (dmem_read_enable && read_fault);
    assign do_write  = capture && dmem_write_enable && !req_fault;

    mem_align u_align (
        .addr_lo       (dmem_address[1:0]),
        .write_mode    (dmem_write_mode),
        .write_data    (dmem_write_data),
        .read_mode     (dmem_read_mode),
        .read_word     (read_word),
        .write_c       (write_lanes),
        .read_data_c   (read_lane),
        .write_fault_c (write_fault),
        .read_fault_c  (read_fault)
    );

    // Array write port; read_word above is sampled before this edge, giving read-first.
    always_ff @(posedge clk) begin
        if (reset_n && do_write) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (write_lanes.byte_en[b]) begin
                    mem[index][8*b +: 8] <= write_lanes.data[8*b +: 8];
                end
            end
        end
    end

`ifdef DATA_RAM_INIT_EN
    if (INIT_FILE == "") begin : g_no_init_file
        $error("data_ram: DATA_RAM_INIT_EN requires a non-empty INIT_FILE");
    end
`else
    if (INIT_FILE != "") begin : g_init_ignored
        $info("data_ram: INIT_FILE ignored without DATA_RAM_INIT_EN");
    end
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_next     = state;
        count_next     = count;
        fault_next     = 1'b0;
        read_data_next = dmem_read_data;
        wait_next      = 1'b0;
        case (state)
            RAM_IDLE: begin
                if (dmem_enable) begin
                    fault_next = req_fault;
                    if (dmem_read_enable) begin
                        read_data_next = req_fault ? '0 : read_lane;
                        if (!req_fault && HAS_WAIT) begin
                            state_next = RAM_BUSY;
                            count_next = CNT_LOAD;
                        end
                    end
                end
            end
            RAM_BUSY: begin
                if (count == '0) begin
                    state_next = RAM_IDLE;
                end else begin
                    count_next = count - CNT_W'(1);
                end
            end
            default: begin
                state_next = RAM_IDLE;
            end
        endcase
        wait_next = (state_next == RAM_BUSY);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= RAM_IDLE;
            count          <= '0;
            dmem_wait      <= 1'b0;
            dmem_fault     <= 1'b0;
            dmem_read_data <= '0;
        end else begin
            state          <= state_next;
            count          <= count_next;
            dmem_wait      <= wait_next;
            dmem_fault     <= fault_next;
            dmem_read_data <= read_data_next;
        end
    end

endmodule
